// File: rtl/ad_frame_ctrl.sv
// Serial clock / chip-select framing for the 16-bit ADC capture path.
// Frames are started on request or by a free-running sample-period timer.
module ad_frame_ctrl #(
  parameter int CLK_DIV       = 4,
  parameter int FRAME_BITS    = 16,
  parameter int QUIET         = 1,
  parameter int SAMPLE_PERIOD = 200
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        en,
  input  logic        clr_ovr,
  output logic        sclk,
  output logic        cs_signal,
  output logic        busy,
  output logic        frame_done,
  output logic [15:0] frame_cnt,
  output logic        overrun
);

  localparam int DIV_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BIT_W = (FRAME_BITS > 1) ? $clog2(FRAME_BITS) : 1;
  localparam int Q_LEN = 2 * CLK_DIV * QUIET;
  localparam int Q_W   = (Q_LEN > 1) ? $clog2(Q_LEN) : 1;
  localparam int TMR_W = $clog2(SAMPLE_PERIOD);

  localparam logic [DIV_W-1:0] DIV_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [BIT_W-1:0] BIT_ZERO = {BIT_W{1'b0}};
  localparam logic [BIT_W-1:0] BIT_ONE  = BIT_W'(1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(FRAME_BITS - 1);
  localparam logic [Q_W-1:0]   Q_ZERO   = {Q_W{1'b0}};
  localparam logic [Q_W-1:0]   Q_ONE    = Q_W'(1);
  localparam logic [Q_W-1:0]   Q_LAST   = Q_W'(Q_LEN - 1);
  localparam logic [TMR_W-1:0] TMR_ZERO = {TMR_W{1'b0}};
  localparam logic [TMR_W-1:0] TMR_ONE  = TMR_W'(1);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(SAMPLE_PERIOD - 1);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_SHIFT = 2'd2,
    ST_QUIET = 2'd3
  } state_t;

  state_t             r_state, w_state_nxt;
  logic [DIV_W-1:0]   r_div, w_div_nxt;
  logic [BIT_W-1:0]   r_bit, w_bit_nxt;
  logic               r_phase, w_phase_nxt;
  logic [Q_W-1:0]     r_quiet, w_quiet_nxt;
  logic [TMR_W-1:0]   r_tmr, w_tmr_nxt;
  logic               r_tick, w_tick_nxt;
  logic               r_sclk, r_cs, r_busy, r_done, r_overrun;
  logic [15:0]        r_frame_cnt;
  logic               w_trig, w_ovr_set;
  logic               w_sclk_nxt, w_cs_nxt, w_busy_nxt, w_done_nxt;

  assign w_trig    = start | r_tick;
  assign w_ovr_set = r_tick & (r_state != ST_IDLE);

  // Period timer: tick is registered, so it lands SAMPLE_PERIOD cycles after en rises.
  always_comb begin
    w_tmr_nxt  = r_tmr;
    w_tick_nxt = 1'b0;
    if (!en) begin
      w_tmr_nxt = TMR_ZERO;
    end else if (r_tmr == TMR_LAST) begin
      w_tmr_nxt  = TMR_ZERO;
      w_tick_nxt = 1'b1;
    end else begin
      w_tmr_nxt = r_tmr + TMR_ONE;
    end
  end

  // Next-state and counter logic; r_phase=0 is the sclk-low half of a bit.
  always_comb begin
    w_state_nxt = r_state;
    w_div_nxt   = r_div;
    w_bit_nxt   = r_bit;
    w_phase_nxt = r_phase;
    w_quiet_nxt = r_quiet;
    case (r_state)
      ST_IDLE: begin
        if (w_trig) begin
          w_state_nxt = ST_SETUP;
          w_div_nxt   = DIV_ZERO;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_SETUP: begin
        if (r_div == DIV_LAST) begin
          w_state_nxt = ST_SHIFT;
          w_div_nxt   = DIV_ZERO;
          w_bit_nxt   = BIT_ZERO;
          w_phase_nxt = 1'b0;
        end else begin
          w_div_nxt = r_div + DIV_ONE;
        end
      end
      ST_SHIFT: begin
        if (r_div != DIV_LAST) begin
          w_div_nxt = r_div + DIV_ONE;
        end else begin
          w_div_nxt = DIV_ZERO;
          if (!r_phase) begin
            w_phase_nxt = 1'b1;
          end else if (r_bit == BIT_LAST) begin
            w_state_nxt = ST_QUIET;
            w_phase_nxt = 1'b0;
            w_quiet_nxt = Q_ZERO;
          end else begin
            w_bit_nxt   = r_bit + BIT_ONE;
            w_phase_nxt = 1'b0;
          end
        end
      end
      ST_QUIET: begin
        if (r_quiet == Q_LAST) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_quiet_nxt = r_quiet + Q_ONE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Output decode from the next state so the registered pins line up with the state.
  always_comb begin
    w_cs_nxt   = !((w_state_nxt == ST_SETUP) || (w_state_nxt == ST_SHIFT));
    w_sclk_nxt = !((w_state_nxt == ST_SHIFT) && !w_phase_nxt);
    w_busy_nxt = (w_state_nxt != ST_IDLE);
    w_done_nxt = (w_state_nxt == ST_QUIET) && (w_quiet_nxt == Q_LAST);
  end

  // State, counters and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_div       <= DIV_ZERO;
      r_bit       <= BIT_ZERO;
      r_phase     <= 1'b0;
      r_quiet     <= Q_ZERO;
      r_tmr       <= TMR_ZERO;
      r_tick      <= 1'b0;
      r_sclk      <= 1'b1;
      r_cs        <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_frame_cnt <= 16'd0;
      r_overrun   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_div   <= w_div_nxt;
      r_bit   <= w_bit_nxt;
      r_phase <= w_phase_nxt;
      r_quiet <= w_quiet_nxt;
      r_tmr   <= w_tmr_nxt;
      r_tick  <= w_tick_nxt;
      r_sclk  <= w_sclk_nxt;
      r_cs    <= w_cs_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
      if (w_done_nxt) begin
        r_frame_cnt <= r_frame_cnt + 16'd1;
      end else begin
        r_frame_cnt <= r_frame_cnt;
      end
      // A dropped tick outranks a simultaneous clear.
      if (w_ovr_set) begin
        r_overrun <= 1'b1;
      end else if (clr_ovr) begin
        r_overrun <= 1'b0;
      end else begin
        r_overrun <= r_overrun;
      end
    end
  end

  assign sclk       = r_sclk;
  assign cs_signal  = r_cs;
  assign busy       = r_busy;
  assign frame_done = r_done;
  assign frame_cnt  = r_frame_cnt;
  assign overrun    = r_overrun;

endmodule

// File: tb/tb_ad_frame_ctrl.sv
// Self-checking bench for ad_frame_ctrl: default instance plus a SAMPLE_PERIOD=100
// instance for the overrun cases.
module tb_ad_frame_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, en, clr_ovr;
  logic        sclk, cs_signal, busy, frame_done, overrun;
  logic [15:0] frame_cnt;
  logic        start_b, en_b, clr_b;
  logic        sclk_b, cs_b, busy_b, done_b, ovr_b;
  logic [15:0] cnt_b;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  ad_frame_ctrl dut_a (
    .clk(clk), .rst(rst), .start(start), .en(en), .clr_ovr(clr_ovr),
    .sclk(sclk), .cs_signal(cs_signal), .busy(busy), .frame_done(frame_done),
    .frame_cnt(frame_cnt), .overrun(overrun)
  );

  ad_frame_ctrl #(.SAMPLE_PERIOD(100)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .en(en_b), .clr_ovr(clr_b),
    .sclk(sclk_b), .cs_signal(cs_b), .busy(busy_b), .frame_done(done_b),
    .frame_cnt(cnt_b), .overrun(ovr_b)
  );

  typedef struct {
    int          cyc;
    logic        start;
    logic        sclk;
    logic        cs;
    logic        busy;
    logic        done;
    logic [15:0] cnt;
  } vec_t;

  vec_t vecs[16];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; start = 1'b0; en = 1'b0; clr_ovr = 1'b0;
    start_b = 1'b0; en_b = 1'b0; clr_b = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // One start pulse in cycle 0, then watch sclk/cs for ncyc cycles.
  task automatic watch_frame(input int ncyc, output int falls, output int cs_low, output int bad_gap);
    int   last;
    logic prev;
    falls = 0; cs_low = 0; bad_gap = 0; last = -1; prev = sclk;
    for (int c = 0; c < ncyc; c++) begin
      @(negedge clk);
      if (prev && !sclk) begin
        if (last >= 0 && (c - last) != 8) bad_gap++;
        last = c;
        falls++;
      end
      prev = sclk;
      if (!cs_signal) cs_low++;
      start = (c == 0);
    end
    start = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   falls, cs_low, bad_gap, rises, first_rise, last_rise;
    logic prev_busy, drv;

    // cyc, start, sclk, cs, busy, done, cnt  (cycle 0 = trigger sampled)
    vecs[0]  = '{0,   1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{1,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[2]  = '{4,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[3]  = '{5,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[4]  = '{8,   1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[5]  = '{9,   1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[6]  = '{13,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[7]  = '{70,  1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[8]  = '{128, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[9]  = '{129, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[10] = '{132, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 16'd0};
    vecs[11] = '{133, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[12] = '{139, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 16'd0};
    vecs[13] = '{140, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 16'd1};
    vecs[14] = '{141, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};
    vecs[15] = '{143, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd1};

    do_reset();
    check("reset_outputs", 32'({sclk, cs_signal, busy, frame_done, overrun, frame_cnt}),
          32'({1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 16'd0}));

    // Single frame, table-driven; the start at cycle 70 lands mid-frame and must be ignored.
    falls = 0; cs_low = 0; bad_gap = 0; last_rise = -1; prev_busy = sclk;
    for (int c = 0; c < 145; c++) begin
      @(negedge clk);
      if (prev_busy && !sclk) begin
        if (last_rise >= 0 && (c - last_rise) != 8) bad_gap++;
        last_rise = c;
        falls++;
      end
      prev_busy = sclk;
      if (!cs_signal) cs_low++;
      drv = 1'b0;
      for (int i = 0; i < 16; i++) begin
        if (vecs[i].cyc == c) begin
          check($sformatf("vec_cyc%0d", c),
                32'({sclk, cs_signal, busy, frame_done, frame_cnt}),
                32'({vecs[i].sclk, vecs[i].cs, vecs[i].busy, vecs[i].done, vecs[i].cnt}));
          drv = vecs[i].start;
        end
      end
      start = drv;
    end
    check("single_falls", 32'(falls), 32'd16);
    check("single_fall_gap", 32'(bad_gap), 32'd0);
    check("single_cs_low", 32'(cs_low), 32'd132);
    check("single_overrun", 32'(overrun), 32'd0);

    // Start and first tick in the same IDLE cycle (c=200); later start mid-frame ignored.
    rises = 0; first_rise = -1; prev_busy = busy;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!prev_busy && busy) begin
        rises++;
        if (first_rise < 0) first_rise = c;
      end
      prev_busy = busy;
      en    = (c < 201);
      start = (c == 200) || (c == 250);
    end
    start = 1'b0;
    check("dual_trig_frames", 32'(rises), 32'd1);
    check("dual_trig_start_cycle", 32'(first_rise), 32'd201);
    check("dual_trig_cnt", 32'(frame_cnt), 32'd2);
    check("dual_trig_overrun", 32'(overrun), 32'd0);

    // Reset mid-frame: sclk is in a low half at cycle 61.
    for (int c = 0; c < 62; c++) begin
      @(negedge clk);
      start = (c == 0);
    end
    start = 1'b0;
    check("pre_reset_sclk_cs", 32'({sclk, cs_signal}), 32'({1'b0, 1'b0}));
    rst = 1'b0;
    #1;
    check("async_reset_sclk_cs", 32'({sclk, cs_signal}), 32'({1'b1, 1'b1}));
    check("async_reset_busy_cnt", 32'({busy, frame_cnt}), 32'({1'b0, 16'd0}));
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    watch_frame(150, falls, cs_low, bad_gap);
    check("post_reset_falls", 32'(falls), 32'd16);
    check("post_reset_gap", 32'(bad_gap), 32'd0);
    check("post_reset_cs_low", 32'(cs_low), 32'd132);
    check("post_reset_cnt", 32'(frame_cnt), 32'd1);

    // Continuous mode, 200-cycle period: ticks at 200, 400, ... 2000.
    do_reset();
    rises = 0; first_rise = -1; last_rise = -1; bad_gap = 0; prev_busy = busy;
    for (int c = 0; c < 2160; c++) begin
      @(negedge clk);
      if (!prev_busy && busy) begin
        rises++;
        if (first_rise < 0) first_rise = c;
        if (last_rise >= 0 && (c - last_rise) != 200) bad_gap++;
        last_rise = c;
      end
      prev_busy = busy;
      en = (c < 2000);
    end
    en = 1'b0;
    check("cont_frames", 32'(rises), 32'd10);
    check("cont_first_start", 32'(first_rise), 32'd201);
    check("cont_spacing", 32'(bad_gap), 32'd0);
    check("cont_overrun", 32'(overrun), 32'd0);
    check("cont_cnt", 32'(frame_cnt), 32'd10);

    // frame_cnt wrap.
    @(negedge clk);
    force dut_a.r_frame_cnt = 16'hFFFF;
    #1;
    release dut_a.r_frame_cnt;
    @(negedge clk);
    check("preload_cnt", 32'(frame_cnt), 32'h0000FFFF);
    watch_frame(150, falls, cs_low, bad_gap);
    check("wrap_falls", 32'(falls), 32'd16);
    check("wrap_cnt", 32'(frame_cnt), 32'd0);

    // SAMPLE_PERIOD=100: ticks at 100..400; 200 and 400 arrive while busy.
    rises = 0; prev_busy = busy_b;
    for (int c = 0; c < 460; c++) begin
      @(negedge clk);
      if (!prev_busy && busy_b) rises++;
      prev_busy = busy_b;
      if (c == 150) check("ovr_before_drop", 32'(ovr_b), 32'd0);
      if (c == 201) check("ovr_set_on_drop", 32'(ovr_b), 32'd1);
      if (c == 251) check("ovr_cleared", 32'(ovr_b), 32'd0);
      if (c == 400) check("ovr_still_clear", 32'(ovr_b), 32'd0);
      if (c == 401) check("ovr_set_wins_clr", 32'(ovr_b), 32'd1);
      if (c == 450) check("ovr_cnt", 32'(cnt_b), 32'd2);
      en_b  = 1'b1;
      clr_b = (c == 250) || (c == 400);
    end
    en_b = 1'b0; clr_b = 1'b0;
    check("ovr_frames_started", 32'(rises), 32'd2);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/ad_frame_ctrl.md
# ad_frame_ctrl

Generates the serial clock and chip-select framing that drives the 16-bit serial ADC capture stage, either one frame on request or continuously at a fixed sample rate. It sits directly upstream of the ADC reader. Its `sclk` and `cs_signal` outputs connect straight to the reader's identically named inputs, and the same `rst` net resets both. It also reports frame completion, busy status, a frame count and a sticky overrun flag to the control logic.

## Interface
- CLK_DIV, 4, `clk` cycles per `sclk` half-period; must be ≥2. Default gives sclk = clk/8.
- FRAME_BITS, 16, number of `sclk` cycles per frame while `cs_signal` is low.
- QUIET, 1, number of `sclk` periods (2·CLK_DIV `clk` cycles each) that `cs_signal` stays high after a frame.
- SAMPLE_PERIOD, 200, `clk` cycles between periodic triggers; must be ≥2.
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  asynchronous, active-low reset.
- start  in  1  single-frame request, sampled only in IDLE.
- en  in  1  continuous-sampling enable; runs the period timer.
- clr_ovr  in  1  clears `overrun`.
- sclk  out  1  serial clock to the ADC/reader; idles high.
- cs_signal  out  1  chip select, active low; idles high.
- busy  out  1  high whenever the state is not IDLE.
- frame_done  out  1  one-`clk` pulse at the end of each frame.
- frame_cnt  out  16  number of completed frames; wraps from 16'hFFFF to 0.
- overrun  out  1  sticky; set when a periodic trigger arrives while busy.

## Operation
- All outputs are registered, so `sclk` and `cs_signal` are glitch-free.
- Reset values: `sclk`=1, `cs_signal`=1, `busy`=0, `frame_done`=0, `frame_cnt`=0, `overrun`=0. Reset also sets state=IDLE and clears every internal counter.
- States:
  - IDLE: `cs`=1, `sclk`=1. A trigger moves to SETUP.
  - SETUP: `cs`=0, `sclk`=1 for CLK_DIV cycles, then moves to SHIFT.
  - SHIFT: FRAME_BITS `sclk` cycles, each a low half then a high half of CLK_DIV cycles. After the high half of the last bit, moves to QUIET.
  - QUIET: `cs`=1, `sclk`=1 for 2·CLK_DIV·QUIET cycles, then returns to IDLE.
- Triggers:
  - A trigger is either `start`=1 or a period tick.
  - If both occur in the same IDLE cycle, exactly one frame starts.
  - `start` outside IDLE is ignored and does not affect `overrun`.
- Period timer:
  - Counts 0..SAMPLE_PERIOD-1 while `en`=1 and ticks on the wrap to 0.
  - When `en`=0 the timer is held at 0. Deasserting `en` mid-frame lets the current frame complete.
  - The first tick occurs SAMPLE_PERIOD cycles after `en` rises.
- Overrun:
  - A tick while `busy`=1 is dropped and sets `overrun`.
  - If set and `clr_ovr` are asserted in the same cycle, set wins.
- Counters:
  - The bit counter covers 0..FRAME_BITS-1 and the half-period divider covers 0..CLK_DIV-1. Both are sized with $clog2.
  - `frame_cnt` increments in the same cycle that `frame_done` is high.

## Timing
- Let t0 be the cycle in which a trigger is sampled in IDLE.
- Cycle t0+1: `cs_signal` goes low, `busy` goes high, `sclk` is still high.
- Cycle t0+1+CLK_DIV: first `sclk` falling edge.
- Subsequent `sclk` edges occur every CLK_DIV cycles, giving FRAME_BITS falling and FRAME_BITS rising edges in total.
- Cycle t0+1+CLK_DIV·(1+2·FRAME_BITS): `cs_signal` goes high. With defaults this is t0+133.
- `frame_done` is high in the last QUIET cycle. With defaults this is t0+140, with `busy` low from t0+141.
- The earliest next frame starts from a trigger sampled at t0+141.
- Frame length in `clk` cycles is 1 + CLK_DIV·(1+2·FRAME_BITS+2·QUIET), which is 141 with defaults. If SAMPLE_PERIOD is at least this length, no overrun occurs.
- When `rst` falls mid-frame, `cs_signal` and `sclk` go high immediately, without waiting for a `clk` edge. Operation resumes on the first `clk` edge after `rst` rises.

## Test plan
- Reset then a single `start` pulse with defaults:
  - `cs_signal` low exactly at t0+1..t0+132.
  - 16 `sclk` falling edges, 8 `clk` apart.
  - `frame_done` at t0+140; `frame_cnt`=1; `overrun`=0.
- `en`=1 with defaults for 2000 cycles:
  - 10 frames, each starting exactly 200 cycles apart.
  - `overrun` stays 0; `frame_cnt`=10.
- SAMPLE_PERIOD=100 with `en`=1:
  - Every second tick is dropped and `overrun`=1.
  - Assert `clr_ovr` in a cycle with no tick → `overrun`=0.
  - Assert `clr_ovr` in the same cycle as a tick-while-busy → `overrun` stays 1.
- `start` and tick in the same IDLE cycle:
  - Exactly one frame and `frame_cnt`+1.
  - A second `start` pulse mid-frame is ignored.
- Drop `rst` at t0+60:
  - `sclk`=1 and `cs_signal`=1 before the next `clk` edge.
  - `frame_cnt`=0 and `busy`=0.
  - A new `start` after reset produces a full 16-bit frame.
- Preload `frame_cnt` to 16'hFFFF via 65535 frames (or force), then run one more frame → `frame_cnt`=0.
